// File: rtl/vme_bus_arbiter.sv
// rtl/vme_bus_arbiter.sv - round-robin arbiter sharing one VME register bus between two requesters
// Optional forced completion of stalled transactions is enabled by defining ARB_TIMEOUT_EN.
module vme_bus_arbiter #(
  parameter int          ADDR_W         = 20,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:2] m0_VMEAddr,
  input  logic [31:0]       m0_VMEWrData,
  input  logic              m0_VMERdMem,
  input  logic              m0_VMEWrMem,
  output logic [31:0]       m0_VMERdData,
  output logic              m0_VMERdDone,
  output logic              m0_VMEWrDone,
  input  logic [ADDR_W-1:2] m1_VMEAddr,
  input  logic [31:0]       m1_VMEWrData,
  input  logic              m1_VMERdMem,
  input  logic              m1_VMEWrMem,
  output logic [31:0]       m1_VMERdData,
  output logic              m1_VMERdDone,
  output logic              m1_VMEWrDone,
  output logic [ADDR_W-1:2] VMEAddr,
  output logic [31:0]       VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [31:0]       VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone,
  output logic              timeout_o
);

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:2] in_addr  [2];
  logic [31:0]       in_wdata [2];
  logic [1:0]        in_rd, in_wr;
  logic [ADDR_W-1:2] lat_addr  [2];
  logic [31:0]       lat_wdata [2];
  logic [31:0]       rd_data   [2];
  logic [1:0]        pend_rd, pend_wr, pend_any;
  logic [1:0]        rd_done, wr_done;
  logic              sel, sel_wr, last, pick, both;
  logic              match, timed_out, complete, timeout_q;
  logic [15:0]       to_cnt;

  assign in_addr[0]  = m0_VMEAddr;
  assign in_addr[1]  = m1_VMEAddr;
  assign in_wdata[0] = m0_VMEWrData;
  assign in_wdata[1] = m1_VMEWrData;
  assign in_rd       = {m1_VMERdMem, m0_VMERdMem};
  assign in_wr       = {m1_VMEWrMem, m0_VMEWrMem};

  assign pend_any = pend_rd | pend_wr;
  assign both     = &pend_any;
  // On a tie the requester not served last wins; a lone requester wins outright.
  assign pick     = both ? ~last : ~pend_any[0];

  assign match     = (state == WAIT) && (sel_wr ? VMEWrDone : VMERdDone);
  assign timed_out = TO_EN && (state == WAIT) && (to_cnt == TO_LAST) && !match;
  assign complete  = match || timed_out;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    VMEAddr   = '0;
    VMEWrData = '0;
    VMERdMem  = 1'b0;
    VMEWrMem  = 1'b0;
    if (state != IDLE) begin
      VMEAddr   = lat_addr[sel];
      VMEWrData = lat_wdata[sel];
      if (state == ISSUE) begin
        VMEWrMem = sel_wr;
        VMERdMem = !sel_wr;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst || !TO_EN || state != WAIT) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 16'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pend_rd   <= '0;
      pend_wr   <= '0;
      rd_done   <= '0;
      wr_done   <= '0;
      sel       <= 1'b0;
      sel_wr    <= 1'b0;
      last      <= 1'b1;
      timeout_q <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        lat_addr[n]  <= '0;
        lat_wdata[n] <= '0;
        rd_data[n]   <= '0;
      end
    end else begin
      rd_done   <= '0;
      wr_done   <= '0;
      timeout_q <= 1'b0;
      // A requester with anything outstanding has its strobes ignored.
      for (int n = 0; n < 2; n++) begin
        if (!pend_any[n] && (in_rd[n] || in_wr[n])) begin
          pend_rd[n]   <= in_rd[n];
          pend_wr[n]   <= in_wr[n];
          lat_addr[n]  <= in_addr[n];
          lat_wdata[n] <= in_wdata[n];
        end
      end
      if (state == IDLE && |pend_any) begin
        sel    <= pick;
        sel_wr <= pend_wr[pick];
        if (both) last <= pick;
      end
      if (complete) begin
        timeout_q <= timed_out;
        if (sel_wr) begin
          pend_wr[sel] <= 1'b0;
          wr_done[sel] <= 1'b1;
        end else begin
          pend_rd[sel] <= 1'b0;
          rd_done[sel] <= 1'b1;
          rd_data[sel] <= timed_out ? ERR_DATA : VMERdData;
        end
      end
    end
  end

  assign m0_VMERdData = rd_data[0];
  assign m1_VMERdData = rd_data[1];
  assign m0_VMERdDone = rd_done[0];
  assign m1_VMERdDone = rd_done[1];
  assign m0_VMEWrDone = wr_done[0];
  assign m1_VMEWrDone = wr_done[1];
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// tb/tb_vme_bus_arbiter.sv - directed bench for vme_bus_arbiter with a completion scoreboard
module tb_vme_bus_arbiter;
  localparam int AW = 20;

  logic          Clk, Rst;
  logic [AW-1:2] m0_VMEAddr, m1_VMEAddr, VMEAddr;
  logic [31:0]   m0_VMEWrData, m1_VMEWrData, m0_VMERdData, m1_VMERdData;
  logic          m0_VMERdMem, m0_VMEWrMem, m1_VMERdMem, m1_VMEWrMem;
  logic          m0_VMERdDone, m0_VMEWrDone, m1_VMERdDone, m1_VMEWrDone;
  logic [31:0]   VMEWrData, VMERdData;
  logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone, timeout_o;

  vme_bus_arbiter #(.ADDR_W(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .m0_VMEAddr(m0_VMEAddr), .m0_VMEWrData(m0_VMEWrData),
    .m0_VMERdMem(m0_VMERdMem), .m0_VMEWrMem(m0_VMEWrMem),
    .m0_VMERdData(m0_VMERdData), .m0_VMERdDone(m0_VMERdDone), .m0_VMEWrDone(m0_VMEWrDone),
    .m1_VMEAddr(m1_VMEAddr), .m1_VMEWrData(m1_VMEWrData),
    .m1_VMERdMem(m1_VMERdMem), .m1_VMEWrMem(m1_VMEWrMem),
    .m1_VMERdData(m1_VMERdData), .m1_VMERdDone(m1_VMERdDone), .m1_VMEWrDone(m1_VMEWrDone),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_strb = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input bit exp_wr, input logic [AW-1:2] exp_addr);
    int n = 0;
    while (!(VMERdMem || VMEWrMem) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_kind"}, {VMEWrMem, VMERdMem}, exp_wr ? 2'b10 : 2'b01);
    check({tag, "_addr"}, VMEAddr, exp_addr);
  endtask

  task automatic serve(input string tag, input bit exp_wr, input logic [AW-1:2] exp_addr,
                       input logic [31:0] rdata, input int delay);
    wait_strobe(tag, exp_wr, exp_addr);
    repeat (delay) tick();
    VMERdData = rdata;
    if (exp_wr) VMEWrDone = 1'b1;
    else        VMERdDone = 1'b1;
    tick();
    VMERdDone = 1'b0;
    VMEWrDone = 1'b0;
    VMERdData = '0;
  endtask

  // Completion monitor: every requester Done must match the oldest expected entry.
  always @(negedge Clk) begin
    logic [3:0] dn;
    exp_t e;
    dn = {m1_VMEWrDone, m1_VMERdDone, m0_VMEWrDone, m0_VMERdDone};
    if (dn != 4'b0) begin
      check("sb_onehot", $countones(dn), 1);
      if (exp_q.size() == 0) begin
        check("sb_unexpected", dn, 4'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_done",
              {|dn[3:2], dn[3] | dn[1], (|dn[3:2]) ? m1_VMERdData : m0_VMERdData},
              {e.req, e.wr, e.data});
      end
    end
    if (!Rst) check("strobe_excl", VMERdMem & VMEWrMem, 1'b0);
    if (prev_strb) check("no_back_to_back", {VMERdMem, VMEWrMem}, 2'b00);
    prev_strb = VMERdMem | VMEWrMem;
  end

  initial begin
    Rst = 1'b1;
    {m0_VMERdMem, m0_VMEWrMem, m1_VMERdMem, m1_VMEWrMem} = '0;
    m0_VMEAddr = '0; m1_VMEAddr = '0; m0_VMEWrData = '0; m1_VMEWrData = '0;
    VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
    tick();
    tick();
    check("rst_slave_bus", {VMEAddr, VMEWrData, VMERdMem, VMEWrMem}, '0);
    check("rst_done", {m0_VMERdDone, m0_VMEWrDone, m1_VMERdDone, m1_VMEWrDone, timeout_o}, '0);
    check("rst_rddata", {m0_VMERdData, m1_VMERdData}, '0);
    Rst = 1'b0;
    tick();

    // m0 write, slave answers 3 cycles after the strobe
    m0_VMEAddr = 18'h4; m0_VMEWrData = 32'h12345678; m0_VMEWrMem = 1'b1;
    exp_q.push_back('{req: 1'b0, wr: 1'b1, data: 32'h0});
    tick();
    m0_VMEWrMem = 1'b0;
    check("t1_no_strobe_t1", {VMERdMem, VMEWrMem}, 2'b00);
    tick();
    check("t1_strobe_t2", {VMERdMem, VMEWrMem}, 2'b01);
    check("t1_addr", VMEAddr, 18'h4);
    check("t1_wdata", VMEWrData, 32'h12345678);
    tick();
    check("t1_wait_hold", {VMEAddr, VMEWrMem}, {18'h4, 1'b0});
    tick();
    tick();
    VMEWrDone = 1'b1;
    check("t1_done_not_early", m0_VMEWrDone, 1'b0);
    tick();
    VMEWrDone = 1'b0;
    check("t1_done_pulse", {m0_VMEWrDone, m1_VMERdDone, m1_VMEWrDone}, 3'b100);
    tick();
    check("t1_done_one_cycle", m0_VMEWrDone, 1'b0);

    // read race: m0 first out of reset history, then m1
    m0_VMEAddr = 18'h10; m1_VMEAddr = 18'h20;
    m0_VMERdMem = 1'b1; m1_VMERdMem = 1'b1;
    exp_q.push_back('{req: 1'b0, wr: 1'b0, data: 32'hA5A5A5A5});
    exp_q.push_back('{req: 1'b1, wr: 1'b0, data: 32'h5A5A5A5A});
    tick();
    m0_VMERdMem = 1'b0; m1_VMERdMem = 1'b0;
    serve("race1_first", 1'b0, 18'h10, 32'hA5A5A5A5, 1);
    serve("race1_second", 1'b0, 18'h20, 32'h5A5A5A5A, 2);
    tick();
    check("race1_m0_data", m0_VMERdData, 32'hA5A5A5A5);
    check("race1_m1_data", m1_VMERdData, 32'h5A5A5A5A);

    // repeated race: m1 wins this time
    m0_VMERdMem = 1'b1; m1_VMERdMem = 1'b1;
    exp_q.push_back('{req: 1'b1, wr: 1'b0, data: 32'h11111111});
    exp_q.push_back('{req: 1'b0, wr: 1'b0, data: 32'h22222222});
    tick();
    m0_VMERdMem = 1'b0; m1_VMERdMem = 1'b0;
    serve("race2_first", 1'b0, 18'h20, 32'h11111111, 1);
    serve("race2_second", 1'b0, 18'h10, 32'h22222222, 1);
    tick();

    // m1 read+write together: write first, then read
    m1_VMEAddr = 18'h30; m1_VMEWrData = 32'hCAFEF00D;
    m1_VMERdMem = 1'b1; m1_VMEWrMem = 1'b1;
    exp_q.push_back('{req: 1'b1, wr: 1'b1, data: 32'h11111111});
    exp_q.push_back('{req: 1'b1, wr: 1'b0, data: 32'h33333333});
    tick();
    m1_VMERdMem = 1'b0; m1_VMEWrMem = 1'b0;
    wait_strobe("rw_write", 1'b1, 18'h30);
    check("rw_wdata", VMEWrData, 32'hCAFEF00D);
    tick();
    VMEWrDone = 1'b1;
    tick();
    VMEWrDone = 1'b0;
    serve("rw_read", 1'b0, 18'h30, 32'h33333333, 1);
    tick();

    // non-matching RdDone during a write WAIT is ignored
    m0_VMEAddr = 18'h8; m0_VMEWrData = 32'h0BADF00D; m0_VMEWrMem = 1'b1;
    exp_q.push_back('{req: 1'b0, wr: 1'b1, data: 32'h22222222});
    tick();
    m0_VMEWrMem = 1'b0;
    wait_strobe("xdone_write", 1'b1, 18'h8);
    tick();
    VMERdDone = 1'b1; VMERdData = 32'hFFFFFFFF;
    tick();
    VMERdDone = 1'b0; VMERdData = '0;
    tick();
    check("xdone_ignored", {m0_VMEWrDone, m0_VMERdDone, VMEAddr}, {2'b00, 18'h8});
    VMEWrDone = 1'b1;
    tick();
    VMEWrDone = 1'b0;
    tick();

    // reset during WAIT of an m0 read drops the transaction
    m0_VMEAddr = 18'h40; m0_VMERdMem = 1'b1;
    tick();
    m0_VMERdMem = 1'b0;
    wait_strobe("abort_read", 1'b0, 18'h40);
    repeat (3) tick();
    check("abort_wait", {m0_VMERdDone, timeout_o, VMEAddr}, {2'b00, 18'h40});
    #2 Rst = 1'b1;
    #1;
    check("abort_async_bus", {VMEAddr, VMEWrData, VMERdMem, VMEWrMem}, '0);
    check("abort_async_data", {m0_VMERdData, m1_VMERdData}, '0);
    tick();
    Rst = 1'b0;
    VMERdDone = 1'b1; VMERdData = 32'h77777777;
    tick();
    VMERdDone = 1'b0; VMERdData = '0;
    m1_VMEAddr = 18'h50; m1_VMERdMem = 1'b1;
    exp_q.push_back('{req: 1'b1, wr: 1'b0, data: 32'h55555555});
    tick();
    m1_VMERdMem = 1'b0;
    serve("after_rst", 1'b0, 18'h50, 32'h55555555, 2);
    repeat (3) tick();
    check("abort_no_m0_data", m0_VMERdData, 32'h0);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
